// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a req/ack memory
// port and buffers {PC+4, IR} pairs for the IF/ID register; redirect flushes.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       im_req,
    output logic [31:0]                im_addr,
    input  logic                       im_ack,
    input  logic [31:0]                im_rdata,
    output logic                       out_valid,
    output logic [31:0]                out_pc_next,
    output logic [31:0]                out_ir,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Handshakes: memory transfer when im_req & im_ack (im_addr held while
    // im_req is high); IF/ID transfer when out_valid & out_ready.
    state_t        r_state, w_state_nxt;
    logic [31:0]   r_fpc, w_fpc_nxt;
    logic [31:0]   r_req_addr, w_req_addr_nxt;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_q_pc [DEPTH];
    logic [31:0]   r_q_ir [DEPTH];
    logic          w_pop, w_push, w_room_idle, w_room_wait;
    logic [31:0]   w_req_plus4;

    assign w_pop       = (r_count != '0) && out_ready && !redirect;
    assign w_room_idle = (r_count != FULL) || w_pop;
    // In WAIT the count never exceeds DEPTH-1, so a push leaves room unless
    // it fills the last slot without a matching pop.
    assign w_room_wait = (r_count != LAST) || w_pop;
    assign w_req_plus4 = r_req_addr + 32'd4;

    always_comb begin
        w_state_nxt    = r_state;
        w_fpc_nxt      = r_fpc;
        w_req_addr_nxt = r_req_addr;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!redirect && w_room_idle) begin
                    w_state_nxt    = S_WAIT;
                    w_req_addr_nxt = r_fpc;
                end
            end
            S_WAIT: begin
                if (im_ack) begin
                    if (redirect) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push    = 1'b1;
                        w_fpc_nxt = w_req_plus4;
                        if (w_room_wait) begin
                            w_req_addr_nxt = w_req_plus4;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else if (redirect) begin
                    w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (im_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect) begin
            w_fpc_nxt = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fpc      <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fpc      <= w_fpc_nxt;
            r_req_addr <= w_req_addr_nxt;
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr] <= w_req_plus4;
            r_q_ir[r_wr_ptr] <= im_rdata;
        end
    end

    assign im_req      = (r_state == S_WAIT) || (r_state == S_DISCARD);
    assign im_addr     = r_req_addr;
    assign out_valid   = (r_count != '0);
    assign out_pc_next = out_valid ? r_q_pc[r_rd_ptr] : 32'd0;
    assign out_ir      = out_valid ? r_q_ir[r_rd_ptr] : 32'd0;
    assign count       = r_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: memory responder, program-order scoreboard,
// directed scenarios and a randomized run with redirects.
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        out_valid;
    logic [31:0] out_pc_next;
    logic [31:0] out_ir;
    logic        out_ready;
    logic [2:0]  count;
    logic [1:0]  dbg_state;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .out_valid(out_valid), .out_pc_next(out_pc_next), .out_ir(out_ir),
        .out_ready(out_ready), .count(count), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    // memory responder controls
    int   lat_cfg   = 0;
    bit   lat_rand  = 0;
    bit   force_ack = 0;

    function automatic logic [31:0] ir_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order after a (re)start at pc: outputs are {pc+4, mem[pc]}, {pc+8, mem[pc+4]}, ...
    task automatic reload(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({pc + 32'd4, ir_of(pc)});
            pc = pc + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        reload(RESET_PC);
        repeat (3) step();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        reload(pc);
    endtask

    // memory responder: acks after a configurable number of waiting cycles
    initial begin
        int wcnt;
        int lat_cur;
        wcnt = 0;
        lat_cur = 0;
        im_ack = 1'b0;
        im_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                im_ack = 1'b1;
                im_rdata = ir_of(im_addr);
            end else if (im_req === 1'b1) begin
                if (wcnt == 0) lat_cur = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
                if (wcnt >= lat_cur) begin
                    im_ack = 1'b1;
                    im_rdata = ir_of(im_addr);
                    wcnt = 0;
                end else begin
                    im_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                im_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // monitor / scoreboard
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            check("count_le_depth", 32'(count > 3'(DEPTH)), 32'd0);
            check("valid_vs_count", 32'(out_valid), 32'(count != 3'd0));
            if (!out_valid) begin
                check("idle_pc_zero", out_pc_next, 32'd0);
                check("idle_ir_zero", out_ir, 32'd0);
            end
            if (out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    check("exp_available", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc_next", out_pc_next, e[63:32]);
                    check("pop_ir", out_ir, e[31:0]);
                end
            end
            if (prev_req && !prev_ack && !prev_rst && im_req)
                check("addr_stable", im_addr, prev_addr);
        end
        prev_req  = im_req;
        prev_ack  = im_ack;
        prev_rst  = rst;
        prev_addr = im_addr;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_nz;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        out_ready = 1'b1;

        // reset state and zero-wait streaming
        lat_cfg = 0;
        do_reset();
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_pc_next", out_pc_next, 32'd0);
        rst = 1'b0;
        step();
        check("s1_im_req", 32'(im_req), 32'd1);
        check("s1_im_addr", im_addr, 32'h0);
        check("s1_out_valid", 32'(out_valid), 32'd0);
        step();
        check("s2_im_addr", im_addr, 32'h4);
        check("s2_out_valid", 32'(out_valid), 32'd1);
        check("s2_pc_next", out_pc_next, 32'h4);
        check("s2_ir", out_ir, ir_of(32'h0));
        step();
        check("s3_im_addr", im_addr, 32'h8);
        check("s3_count", 32'(count), 32'd1);
        check("s3_pc_next", out_pc_next, 32'h8);
        repeat (8) step();

        // fill with out_ready low, then a single pop
        out_ready = 1'b0;
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (count == 3'd4) break;
        end
        repeat (2) step();
        check("full_count", 32'(count), 32'd4);
        check("full_im_req", 32'(im_req), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop1_count", 32'(count), 32'd3);
        check("pop1_im_req", 32'(im_req), 32'd1);
        check("pop1_im_addr", im_addr, 32'h10);
        step();
        check("refill_count", 32'(count), 32'd4);

        // redirect while a slow request is outstanding
        out_ready = 1'b1;
        lat_cfg = 2;
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (im_req && im_addr == 32'h8) break;
        end
        check("disc_req_addr", im_addr, 32'h8);
        step();
        do_redirect(32'h40);
        step();
        redirect = 1'b0;
        check("disc_out_valid", 32'(out_valid), 32'd0);
        check("disc_count", 32'(count), 32'd0);
        check("disc_im_req", 32'(im_req), 32'd1);
        check("disc_im_addr", im_addr, 32'h8);
        seen_nz = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (count != 3'd0) seen_nz = 1'b1;
            if (im_req && im_addr != 32'h8) break;
        end
        check("disc_no_push", 32'(seen_nz), 32'd0);
        check("disc_new_addr", im_addr, 32'h40);
        repeat (12) step();

        // redirect coincident with ack and pop at two entries, wrapping address
        out_ready = 1'b0;
        lat_cfg = 2;
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            #1;
            if (count == 3'd2 && im_ack) break;
        end
        check("coinc_pre_count", 32'(count), 32'd2);
        check("coinc_pre_ack", 32'(im_ack), 32'd1);
        out_ready = 1'b1;
        do_redirect(32'hFFFF_FFF8);
        step();
        redirect = 1'b0;
        check("coinc_count", 32'(count), 32'd0);
        check("coinc_out_valid", 32'(out_valid), 32'd0);
        check("coinc_im_req", 32'(im_req), 32'd0);
        step();
        check("coinc_im_req2", 32'(im_req), 32'd1);
        check("coinc_im_addr", im_addr, 32'hFFFF_FFF8);
        lat_cfg = 0;
        repeat (10) step();

        // randomized run: random ready, latency and redirects
        lat_rand = 1'b1;
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0)
                do_redirect($urandom & 32'hFFFF_FFFC);
            else
                redirect = 1'b0;
        end
        redirect = 1'b0;
        lat_rand = 1'b0;

        // reset during an outstanding request with a stale ack
        lat_cfg = 3;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (im_req) break;
        end
        check("midrst_pre_req", 32'(im_req), 32'd1);
        rst = 1'b1;
        force_ack = 1'b1;
        reload(RESET_PC);
        step();
        check("midrst_im_req", 32'(im_req), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0;
        force_ack = 1'b0;
        step();
        check("midrst_first_req", 32'(im_req), 32'd1);
        check("midrst_first_addr", im_addr, RESET_PC);
        repeat (20) step();
        check("midrst_streaming", 32'(out_valid | im_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
